// File: rtl/an_encoder_seq_30bits_if.sv
// Handshake bundle for the AN-code product encoder: input word channel,
// output codeword channel and status. The optional self-check flag exists
// only when ANENC_SELFCHECK_EN is defined.
interface an_encoder_seq_30bits_if #(
  parameter int unsigned DATA_W = 30,
  parameter int unsigned CODE_W = 41
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_code;
  logic              busy;

`ifdef ANENC_SELFCHECK_EN
  logic              chk_err;

  // Producer/consumer side of the encoder.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_code, busy, chk_err
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_code, busy, chk_err
  );
`else
  // Producer/consumer side of the encoder.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_code, busy
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_code, busy
  );
`endif

endinterface

// File: rtl/an_encoder_seq_30bits.sv
// Sequential AN-code encoder: codeword = N * A, computed LSB-first with one
// shift-and-add per cycle over the A_W bits of A. One word in flight at a time.
// Optional feature macro: ANENC_SELFCHECK_EN adds a mod-A residue checker on
// the final sum and drives chk_err throughout DONE if the residue is nonzero.
module an_encoder_seq_30bits #(
  parameter int unsigned DATA_W = 30,
  parameter int unsigned A      = 83,
  parameter int unsigned A_W    = 7,
  parameter int unsigned CODE_W = 41
) (
  input  logic clk,
  input  logic rst,
  an_encoder_seq_30bits_if.slave enc_if
);

  // Iteration counter width and a power-of-two padded copy of A so the
  // counter can index it without running past the vector.
  localparam int unsigned CNT_W    = (A_W > 1) ? $clog2(A_W) : 1;
  localparam int unsigned A_BITS_W = 1 << CNT_W;
  localparam logic [A_BITS_W-1:0] A_BITS   = A_BITS_W'(A);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(A_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [CODE_W-1:0] mcand_q;
  logic [CODE_W-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CODE_W-1:0] out_code_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;

  logic [CODE_W-1:0] partial_d;
  logic [CODE_W-1:0] acc_d;

  // Partial product for the current bit of A and the running sum after it.
  always_comb begin
    partial_d = '0;
    if (A_BITS[cnt_q]) begin
      partial_d = mcand_q << cnt_q;
    end
    acc_d = acc_q + partial_d;
  end

`ifdef ANENC_SELFCHECK_EN
  logic             chk_err_q;
  logic [A_W-1:0]   residue_d;

  // Bit-serial long division by A: remainder of v mod A.
  function automatic logic [A_W-1:0] residue_mod_a(input logic [CODE_W-1:0] v);
    logic [A_W:0] r;
    r = '0;
    for (int i = int'(CODE_W) - 1; i >= 0; i--) begin
      r = {r[A_W-1:0], v[i]};
      if (r >= (A_W+1)'(A)) begin
        r = r - (A_W+1)'(A);
      end
    end
    return r[A_W-1:0];
  endfunction

  // Residue of the sum that will become the codeword.
  always_comb begin
    residue_d = residue_mod_a(acc_d);
  end
`endif

  // Control FSM and datapath registers; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mcand_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_code_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ANENC_SELFCHECK_EN
      chk_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enc_if.in_valid) begin
            mcand_q    <= CODE_W'(enc_if.in_data);
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_MUL;
          end
        end

        ST_MUL: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            out_code_q  <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
`ifdef ANENC_SELFCHECK_EN
            chk_err_q   <= (residue_d != '0);
`endif
          end
        end

        ST_DONE: begin
          // Codeword held until taken; no new word accepted on this edge.
          if (enc_if.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
`ifdef ANENC_SELFCHECK_EN
            chk_err_q   <= 1'b0;
`endif
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign enc_if.in_ready  = in_ready_q;
  assign enc_if.out_valid = out_valid_q;
  assign enc_if.out_code  = out_code_q;
  assign enc_if.busy      = busy_q;
`ifdef ANENC_SELFCHECK_EN
  assign enc_if.chk_err   = chk_err_q;
`endif

endmodule

// File: tb/tb_an_encoder_seq_30bits.sv
// Self-checking bench for an_encoder_seq_30bits: directed cases plus random
// words compared against N*83 computed with plain 64-bit arithmetic.
module tb_an_encoder_seq_30bits;

  localparam int unsigned DATA_W = 30;
  localparam int unsigned CODE_W = 41;
  localparam longint unsigned A_CONST = 83;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  an_encoder_seq_30bits_if #(.DATA_W(DATA_W), .CODE_W(CODE_W)) enc_if ();

  an_encoder_seq_30bits dut (
    .clk    (clk),
    .rst    (rst),
    .enc_if (enc_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count a comparison and report it if the observed value is wrong.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  64'(enc_if.in_ready),  64'd1);
    check({tag, "_out_valid"}, 64'(enc_if.out_valid), 64'd0);
    check({tag, "_out_code"},  64'(enc_if.out_code),  64'd0);
    check({tag, "_busy"},      64'(enc_if.busy),      64'd0);
`ifdef ANENC_SELFCHECK_EN
    check({tag, "_chk_err"},   64'(enc_if.chk_err),   64'd0);
`endif
  endtask

  // Encode one word, hold DONE for 'hold' cycles with ignored in_valid pulses,
  // then complete the handshake and confirm no word is taken on that edge.
  task automatic encode(input logic [DATA_W-1:0] n, input int hold);
    logic [63:0] exp;
    int cyc;
    exp = 64'(n) * A_CONST;

    cyc = 0;
    while (!enc_if.in_ready && cyc < 20) begin
      step();
      cyc++;
    end
    check("in_ready_wait", 64'(enc_if.in_ready), 64'd1);

    enc_if.in_valid = 1'b1;
    enc_if.in_data  = n;
    step();
    enc_if.in_valid = 1'b0;
    enc_if.in_data  = DATA_W'($urandom);

    cyc = 0;
    while (!enc_if.out_valid && cyc < 20) begin
      check("in_ready_mul", 64'(enc_if.in_ready), 64'd0);
      check("busy_mul",     64'(enc_if.busy),     64'd1);
      step();
      cyc++;
    end
    check("latency",  64'(cyc),             64'd7);
    check("out_code", 64'(enc_if.out_code), exp);
    check("residue",  64'(enc_if.out_code) % A_CONST, 64'd0);
    check("busy_done", 64'(enc_if.busy),    64'd1);
`ifdef ANENC_SELFCHECK_EN
    check("chk_err", 64'(enc_if.chk_err), 64'd0);
`endif

    for (int h = 0; h < hold; h++) begin
      enc_if.in_valid = 1'b1;
      enc_if.in_data  = DATA_W'($urandom);
      step();
      check("hold_valid",    64'(enc_if.out_valid), 64'd1);
      check("hold_code",     64'(enc_if.out_code),  exp);
      check("hold_in_ready", 64'(enc_if.in_ready),  64'd0);
    end

    enc_if.out_ready = 1'b1;
    enc_if.in_valid  = 1'b1;
    enc_if.in_data   = DATA_W'($urandom);
    step();
    enc_if.out_ready = 1'b0;
    enc_if.in_valid  = 1'b0;
    check("post_out_valid", 64'(enc_if.out_valid), 64'd0);
    check("post_in_ready",  64'(enc_if.in_ready),  64'd1);
    check("post_busy",      64'(enc_if.busy),      64'd0);
    check("post_code_hold", 64'(enc_if.out_code),  exp);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    enc_if.in_valid  = 1'b0;
    enc_if.in_data   = '0;
    enc_if.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_vals("reset");
    step();
    step();
    rst = 1'b0;
    step();
    check_reset_vals("after_reset");

    // Directed words, including the back-to-back 0 then 5 pair.
    encode(DATA_W'(1), 0);
    encode(DATA_W'(0), 0);
    encode(DATA_W'(5), 0);
    encode({DATA_W{1'b1}}, 0);
    check("max_expected_const", 64'({DATA_W{1'b1}}) * A_CONST, 64'd89120571309);
    encode(DATA_W'(12345), 3);

    // Reset while iteration 3 is executing.
    enc_if.in_valid = 1'b1;
    enc_if.in_data  = DATA_W'(777777);
    step();
    enc_if.in_valid = 1'b0;
    step();
    step();
    step();
    #1;
    rst = 1'b1;
    #1;
    check_reset_vals("mid_mul_reset");
    step();
    rst = 1'b0;
    step();
    check_reset_vals("mid_mul_release");
    encode(DATA_W'(1000), 1);

    // Random words with random DONE hold time.
    for (int i = 0; i < 1000; i++) begin
      encode(DATA_W'($urandom), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run cannot hang.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
